bpred_table_sched: RTL

BPRED_TABLE_SCHED -- requirements
Module: bpred_table_sched

---
 rtl/bpred_table_sched.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bpred_table_sched.sv
// Branch predictor table of 2-bit counters behind one access port, shared by fetch lookups and a FIFO of resolved updates.
// Define BPRED_BYPASS_EN to let lookups see the youngest queued update for the same index.
module bpred_table_sched #(
    parameter int IDX_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lk_req,
    input  logic [IDX_W-1:0]         lk_idx,
    output logic                     lk_ready,
    output logic                     lk_valid,
    output logic                     lk_pred,
    input  logic                     up_req,
    input  logic [IDX_W-1:0]         up_idx,
    input  logic                     up_taken,
    output logic                     up_ready,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(DEPTH / 2);

    typedef enum logic {
        LOOKUP_PRI,
        DRAIN_PRI
    } arb_state_t;

    arb_state_t       state, state_next;
    logic [1:0]       ctr [ENTRIES];
    logic [IDX_W-1:0] q_idx [DEPTH];
    logic             q_taken [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             full, empty, push, pop, lk_accept, pred_sel;
    logic [IDX_W-1:0] hd_idx;
    logic             hd_taken;

    function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'b01;
        else
            return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign up_ready = !full;
    assign lk_ready = (state == LOOKUP_PRI);
    assign q_count  = count;
    assign push     = up_req && up_ready;
    assign lk_accept = lk_req && lk_ready;
    // The port goes to the queue whenever no lookup claims it; in DRAIN_PRI lookups are blocked.
    assign pop      = !empty && !lk_accept;
    assign hd_idx   = q_idx[rd_ptr];
    assign hd_taken = q_taken[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            LOOKUP_PRI: if (count_next == FULL_CNT) state_next = DRAIN_PRI;
            DRAIN_PRI:  if (count_next <= HALF_CNT) state_next = LOOKUP_PRI;
            default:    state_next = LOOKUP_PRI;
        endcase
    end

`ifdef BPRED_BYPASS_EN
    logic             byp_hit, byp_val;
    logic [PTR_W-1:0] pos;

    // Scan oldest to youngest so the last match (the youngest) wins.
    always_comb begin
        byp_hit = 1'b0;
        byp_val = 1'b0;
        pos     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pos = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (q_idx[pos] == lk_idx)) begin
                byp_hit = 1'b1;
                byp_val = q_taken[pos];
            end
        end
        pred_sel = byp_hit ? byp_val : ctr[lk_idx][1];
    end
`else
    assign pred_sel = ctr[lk_idx][1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOOKUP_PRI;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lk_valid <= 1'b0;
            lk_pred  <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            lk_valid <= lk_accept;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (lk_accept) lk_pred <= pred_sel;
        end
    end

    // Queue payload carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr]   <= up_idx;
            q_taken[wr_ptr] <= up_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < ENTRIES; e++) ctr[e] <= 2'b01;
        end else if (pop) begin
            ctr[hd_idx] <= sat_update(ctr[hd_idx], hd_taken);
        end
    end

endmodule
